// File: rtl/spi_master.sv
// SPI master with runtime divider, CPOL/CPHA, MSB-first shifting and done pulse.
// Optional macro SPI_MASTER_AUTO_CS_EN drives spi_cs_n from busy instead of cs_n_in.
module spi_master #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_strobe,
  input  logic              rx_strobe,
  input  logic [DATA_W-1:0] din,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              cs_n_in,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic              spi_do,
  input  logic              spi_di,
  output logic              spi_cs_n
);
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                strobe_q;
  logic [DIV_W-1:0]    div_q, div_d, cnt_q, cnt_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d;
  logic [HW-1:0]       half_q, half_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d, dout_q, dout_d;
  logic                rxbit_q, rxbit_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic                start_s, boundary_s, leading_s, last_s, shift_s, sample_s;

  assign start_s    = (tx_strobe | rx_strobe) & ~strobe_q & (state_q == IDLE);
  assign boundary_s = (state_q == XFER) && (cnt_q == div_q);
  assign leading_s  = ~half_q[0];
  assign last_s     = boundary_s && (half_q == LAST_HALF);
  // CPHA=1 holds the MSB through the first leading edge, so that edge does not shift.
  assign shift_s    = boundary_s && (cpha_q ? (leading_s && (half_q != '0)) : ~leading_s);
  assign sample_s   = boundary_s && (cpha_q ? ~leading_s : leading_s);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      strobe_q <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      half_q   <= '0;
      shreg_q  <= '0;
      rxbit_q  <= 1'b0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      strobe_q <= tx_strobe | rx_strobe;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      half_q   <= half_d;
      shreg_q  <= shreg_d;
      rxbit_q  <= rxbit_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
    end
  end

  // Next-state, timing counters and shift register.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    shreg_d = shreg_q;
    rxbit_d = rxbit_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = XFER;
          div_d   = div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          cnt_d   = '0;
          half_d  = '0;
          shreg_d = tx_strobe ? din : '1;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (boundary_s) begin
          cnt_d  = '0;
          half_d = half_q + 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
        end
        if (sample_s) begin
          rxbit_d = spi_di;
        end else begin
          rxbit_d = rxbit_q;
        end
        if (shift_s) begin
          shreg_d = {shreg_q[DATA_W-2:0], rxbit_q};
        end else begin
          shreg_d = shreg_q;
        end
        if (last_s) begin
          state_d = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values.
  always_comb begin
    busy_d = (state_d == XFER);
    done_d = last_s;
    if (last_s) begin
      dout_d = {shreg_q[DATA_W-2:0], (cpha_q ? spi_di : rxbit_q)};
    end else begin
      dout_d = dout_q;
    end
    if (state_d == XFER) begin
      mosi_d = shreg_d[DATA_W-1];
    end else begin
      mosi_d = 1'b1;
    end
    if (start_s) begin
      sclk_d = cpol;
    end else if (boundary_s) begin
      sclk_d = ~sclk_q;
    end else begin
      sclk_d = sclk_q;
    end
`ifdef SPI_MASTER_AUTO_CS_EN
    cs_n_d = ~busy_d;
`else
    cs_n_d = cs_n_in;
`endif
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_clk  = sclk_q;
  assign spi_do   = mosi_q;
  assign spi_cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master (DATA_W=8) with a slave model and transfer-level reference.
module tb_spi_master;
  logic       clk, reset, tx_strobe, rx_strobe, cpol, cpha, cs_n_in, spi_di;
  logic [7:0] din, div, dout;
  logic       busy, done, spi_clk, spi_do, spi_cs_n;
  int         n_cmp = 0;
  int         n_err = 0;

  spi_master #(.DATA_W(8), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .tx_strobe(tx_strobe), .rx_strobe(rx_strobe),
    .din(din), .div(div), .cpol(cpol), .cpha(cpha), .cs_n_in(cs_n_in),
    .dout(dout), .busy(busy), .done(done), .spi_clk(spi_clk), .spi_do(spi_do),
    .spi_di(spi_di), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: plain; 1: extra strobe edge mid-transfer; 2: strobe held high through completion
  task automatic run_xfer(input bit use_tx, input bit use_rx, input logic [7:0] d,
                          input logic [7:0] dv, input bit pol, input bit pha,
                          input logic [7:0] sw, input int mode);
    logic [7:0] exp_mosi, mosi_got;
    int         n_mosi, toggles, busy_cnt, sidx, dones, guard;
    logic       prev_sclk, prev_do, cs_prev;
    bit         lead, smp;
    exp_mosi = use_tx ? d : 8'hFF;
    @(negedge clk);
    din = d; div = dv; cpol = pol; cpha = pha;
    tx_strobe = use_tx; rx_strobe = use_rx;
    spi_di = sw[7];
    cs_prev = cs_n_in;
    @(negedge clk);
    chk("busy_rise", busy, 1'b1);
    chk("sclk_start_lvl", spi_clk, pol);
    chk("mosi_msb_first", spi_do, exp_mosi[7]);
    if (mode != 2) begin
      tx_strobe = 1'b0; rx_strobe = 1'b0;
    end
    din = 8'($urandom); div = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
    prev_sclk = pol; prev_do = spi_do;
    toggles = 0; busy_cnt = 0; n_mosi = 0; sidx = 0; dones = 0; mosi_got = 8'h00; guard = 0;
    while (guard < 10000) begin
      guard++;
      if (spi_clk !== prev_sclk) begin
        toggles++;
        chk("half_period", busy_cnt, toggles * (int'(dv) + 1));
        lead = (spi_clk != pol);
        smp  = pha ? !lead : lead;
        if (smp) begin
          mosi_got = {mosi_got[6:0], prev_do};
          n_mosi++;
        end else if (pha) begin
          if (sidx < 8) spi_di = sw[7 - sidx];
          sidx++;
        end else begin
          sidx++;
          if (sidx < 8) spi_di = sw[7 - sidx];
        end
        prev_sclk = spi_clk;
      end
`ifdef SPI_MASTER_AUTO_CS_EN
      chk("cs_auto", spi_cs_n, !busy);
`else
      chk("cs_follow", spi_cs_n, cs_prev);
      cs_n_in = 1'($urandom);
      cs_prev = cs_n_in;
`endif
      if (done) dones++;
      prev_do = spi_do;
      if (!busy) break;
      busy_cnt++;
      if (mode == 1 && busy_cnt == 5) begin
        tx_strobe = 1'b1; din = ~d;
      end
      if (mode == 1 && busy_cnt == 6) tx_strobe = 1'b0;
      @(negedge clk);
    end
    if (guard >= 10000) chk("busy_timeout", busy, 1'b0);
    chk("busy_len", busy_cnt, 16 * (int'(dv) + 1));
    chk("sclk_toggles", toggles, 16);
    chk("done_pulse", done, 1'b1);
    chk("done_count", dones, 1);
    chk("mosi_bits", n_mosi, 8);
    chk("mosi_word", mosi_got, exp_mosi);
    chk("dout_word", dout, sw);
    chk("mosi_idle", spi_do, 1'b1);
    chk("sclk_idle", spi_clk, pol);
    @(negedge clk);
    chk("done_drop", done, 1'b0);
    chk("no_retrigger", busy, 1'b0);
    @(negedge clk);
    chk("no_retrigger2", busy, 1'b0);
    chk("dout_hold", dout, sw);
    tx_strobe = 1'b0; rx_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] d, sw;
    int         guard;
    clk = 1'b0; reset = 1'b1; tx_strobe = 1'b0; rx_strobe = 1'b0;
    din = 8'h00; div = 8'h00; cpol = 1'b0; cpha = 1'b0; cs_n_in = 1'b1; spi_di = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_mosi", spi_do, 1'b1);
    chk("rst_sclk", spi_clk, 1'b0);
    chk("rst_cs", spi_cs_n, 1'b1);
    reset = 1'b0;

    // abort mid-transfer, then a strobe held across reset release starts at once
    @(negedge clk);
    tx_strobe = 1'b1; din = 8'h5A; div = 8'd0;
    repeat (6) @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_dout", dout, 8'h00);
    chk("abort_mosi", spi_do, 1'b1);
    chk("abort_sclk", spi_clk, 1'b0);
    chk("abort_cs", spi_cs_n, 1'b1);
    @(negedge clk);
    chk("abort_done2", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("start_after_rst", busy, 1'b1);
    guard = 0;
    while (busy && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    chk("post_rst_xfer_end", busy, 1'b0);
    tx_strobe = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(1'b1, 1'b0, 8'hA5, 8'd0, 1'b0, 1'b0, 8'h3C, 0);
    run_xfer(1'b0, 1'b1, 8'h00, 8'd3, 1'b1, 1'b1, 8'h81, 0);
    run_xfer(1'b1, 1'b0, 8'hC3, 8'd1, 1'b0, 1'b1, 8'h6E, 1);
    run_xfer(1'b1, 1'b1, 8'h34, 8'd2, 1'b1, 1'b0, 8'h34, 2);
    run_xfer(1'b1, 1'b0, 8'h96, 8'hFF, 1'b1, 1'b0, 8'h2D, 0);
    for (int i = 0; i < 14; i++) begin
      bit t, r;
      t = 1'($urandom); r = 1'($urandom);
      if (!t && !r) r = 1'b1;
      d = 8'($urandom); sw = 8'($urandom);
      run_xfer(t, r, d, 8'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), sw,
               $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
- REQ-001: Parameter DATA_W, default 8, transfer word width in bits (legal 4..32).
- REQ-002: Parameter DIV_W, default 8, width of the runtime clock-divider input.
- REQ-003: clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: tx_strobe  input  1  request a transfer sending din.
- REQ-006: rx_strobe  input  1  request a read-only transfer sending all-ones.
- REQ-007: din  input  DATA_W  word to transmit.
- REQ-008: div  input  DIV_W  SCLK half-period = div+1 clk cycles.
- REQ-009: cpol  input  1  SCLK idle level.
- REQ-010: cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge.
- REQ-011: cs_n_in  input  1  software chip-select level (macro-dependent, see Configuration).
- REQ-012: dout  output  DATA_W  last received word.
- REQ-013: busy  output  1  transfer in progress.
- REQ-014: done  output  1  one-cycle pulse at transfer completion.
- REQ-015: spi_clk  output  1  SCLK.
- REQ-016: spi_do  output  1  MOSI, MSB first.
- REQ-017: spi_di  input  1  MISO.
- REQ-018: spi_cs_n  output  1  active-low chip select.

Function
- REQ-019: Start condition: rising edge of (tx_strobe | rx_strobe), detected against its value registered on the previous cycle, while busy=0.
- REQ-020: On start, the shift register SHALL load din if tx_strobe=1, else all-ones. tx_strobe SHALL win when both strobes are high.
- REQ-021: On start, div, cpol and cpha SHALL be latched. Input changes during a transfer SHALL have no effect until the next start.
- REQ-022: busy SHALL go to 1 on the cycle after the start condition and stay 1 for exactly 2*DATA_W*(div+1) cycles.
- REQ-023: The start edge SHALL be ignored (not queued) while busy=1.
- REQ-024: States: IDLE -> XFER on start. XFER runs 2*DATA_W half-periods. XFER -> IDLE after the last half-period.
- REQ-025: spi_clk SHALL equal the latched cpol in IDLE and SHALL toggle at each half-period boundary in XFER.
- REQ-026: CPHA=0 edge behaviour: spi_do SHALL present the MSB from the first XFER cycle; spi_di SHALL be sampled on leading edges; the shift register SHALL shift on trailing edges.
- REQ-027: CPHA=1 edge behaviour: the shift register SHALL shift on leading edges (the first leading edge presents the MSB); spi_di SHALL be sampled on trailing edges.
- REQ-028: Shifting SHALL be MSB-first: the received bit enters at bit 0 and spi_do = shift register MSB.
- REQ-029: On the XFER -> IDLE cycle, dout SHALL take the completed received word and done SHALL pulse high for one cycle.
- REQ-030: dout SHALL hold its value until the next completion.
- REQ-031: A new start SHALL be accepted on the cycle after done at the earliest. A strobe that is already high at that point SHALL NOT retrigger (edge required).
- REQ-032: spi_do SHALL be 1 in IDLE.
- REQ-033: The internal half-period counter SHALL be DIV_W bits wide. div=all-ones SHALL NOT overflow.

Reset
- REQ-034: While reset=1: state IDLE, busy=0, done=0, dout=0, spi_do=1, spi_clk=0, spi_cs_n=1, latched cpol=0, cpha=0, div=0, registered strobe=0.
- REQ-035: Reset asserted mid-transfer SHALL abort the transfer with no done pulse and no dout update.
- REQ-036: A strobe held high across reset release SHALL start a transfer on the first cycle after release (the registered strobe is 0).

Configuration
- REQ-037: Macro SPI_MASTER_AUTO_CS_EN. When defined, spi_cs_n SHALL be registered low from the cycle busy rises through the last XFER cycle, SHALL go high with done, and cs_n_in SHALL be ignored.
- REQ-038: When SPI_MASTER_AUTO_CS_EN is undefined, spi_cs_n SHALL equal cs_n_in registered by one clk.

Verification
- REQ-039: DATA_W=8, div=0, cpol=0, cpha=0, tx_strobe pulse with din=0xA5, slave echoes 0x3C -> MOSI bits 1,0,1,0,0,1,0,1; busy high 16 cycles; done pulse; dout=0x3C.
- REQ-040: rx_strobe with div=3, cpol=1, cpha=1, slave sends 0x81 -> MOSI all-ones, SCLK idles high, half-period 4 cycles, busy 64 cycles, dout=0x81.
- REQ-041: Second tx_strobe edge at mid-transfer -> ignored; dout reflects the first transfer only; exactly one done pulse.
- REQ-042: Reset asserted at cycle 5 of a transfer -> all outputs at reset values next cycle; no done pulse; dout stays 0.
- REQ-043: DATA_W=16, din=0x1234, loopback spi_do->spi_di, both strobes high together -> dout=0x1234; busy 32*(div+1) cycles.
- REQ-044: With SPI_MASTER_AUTO_CS_EN defined -> spi_cs_n low exactly while busy=1. Without it, toggling cs_n_in -> spi_cs_n follows one cycle later.
